// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller: RV32I main decoder for the decode stage.
//
// The opcode, funct3 and funct7 of the current instruction are decoded
// combinationally. The resulting control bundle is registered, which forms the
// decode/execute control pipeline register. Results appear one clock after the
// inputs are applied. Illegal or unknown encodings produce the all-zero bundle,
// which acts as a NOP.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (clears every output)
//   opcode      instruction[6:0]
//   f3          instruction[14:12] (funct3)
//   f7          instruction[31:25] (funct7)
//   regWR       register-file write enable
//   memWR       data-memory write enable
//   wbCtrl      write-back select: 00 ALU, 01 load data, 10 PC+4
//   aluOp       ALU operation, encoded as {bit, funct3}
//   aluS1       ALU operand A select: 0 rs1, 1 PC
//   aluS2       ALU operand B select: 0 rs2, 1 immediate
//   branchCtrl  branch condition (funct3 of a legal branch, else 0)
//   memCtrl     memory size/sign (funct3 of a legal load/store, else 0)
//   doBranch    conditional branch
//   doJump      JAL or JALR
// -----------------------------------------------------------------------------
module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic       regWR,
    output logic       memWR,
    output logic [1:0] wbCtrl,
    output logic [3:0] aluOp,
    output logic       aluS1,
    output logic       aluS2,
    output logic [2:0] branchCtrl,
    output logic [2:0] memCtrl,
    output logic       doBranch,
    output logic       doJump
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I_ALU  = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic [1:0] wb_ctrl;
        logic [3:0] alu_op;
        logic       alu_s1;
        logic       alu_s2;
        logic [2:0] branch_ctrl;
        logic [2:0] mem_ctrl;
        logic       do_branch;
        logic       do_jump;
    } ctrl_t;

    ctrl_t ctrl_d, ctrl_q;
    logic  legal;

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        ctrl_d = '0;
        legal  = 1'b0;

        unique case (opcode)
            OP_R: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_ALU;
                ctrl_d.alu_op = {f7[5], f3};
                // Only SUB and SRA may use the alternate funct7.
                legal = (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_I_ALU: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_ALU;
                ctrl_d.alu_s2 = 1'b1;
                // funct7 only distinguishes SRAI from SRLI; elsewhere it is
                // part of the immediate.
                ctrl_d.alu_op = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
                legal = 1'b1;
            end
            OP_LOAD: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_LOAD;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
                ctrl_d.mem_ctrl = f3;
                legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OP_STORE: begin
                ctrl_d.mem_wr = 1'b1;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
                ctrl_d.mem_ctrl = f3;
                legal = (f3 <= 3'b010);
            end
            OP_BRANCH: begin
                ctrl_d.do_branch = 1'b1;
                ctrl_d.branch_ctrl = f3;
                ctrl_d.alu_s1 = 1'b1;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
                legal = !(f3 == 3'b010 || f3 == 3'b011);
            end
            OP_LUI: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_ALU;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_PASSB;
                legal = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_ALU;
                ctrl_d.alu_s1 = 1'b1;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
                legal = 1'b1;
            end
            OP_JAL: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_PC4;
                ctrl_d.do_jump = 1'b1;
                ctrl_d.alu_s1 = 1'b1;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
                legal = 1'b1;
            end
            OP_JALR: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.wb_ctrl = WB_PC4;
                ctrl_d.do_jump = 1'b1;
                ctrl_d.alu_s2 = 1'b1;
                ctrl_d.alu_op = ALU_ADD;
                legal = (f3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings collapse to the NOP bundle, so no write enable
        // can leak through.
        if (!legal) begin
            ctrl_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input before any flop updates on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign regWR      = ctrl_q.reg_wr;
    assign memWR      = ctrl_q.mem_wr;
    assign wbCtrl     = ctrl_q.wb_ctrl;
    assign aluOp      = ctrl_q.alu_op;
    assign aluS1      = ctrl_q.alu_s1;
    assign aluS2      = ctrl_q.alu_s2;
    assign branchCtrl = ctrl_q.branch_ctrl;
    assign memCtrl    = ctrl_q.mem_ctrl;
    assign doBranch   = ctrl_q.do_branch;
    assign doJump     = ctrl_q.do_jump;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller: directed self-checking bench for the RV32I controller.
// Output bundle order: {regWR, memWR, wbCtrl, aluOp, aluS1, aluS2,
//                       branchCtrl, memCtrl, doBranch, doJump} (18 bits).
// -----------------------------------------------------------------------------
module tb_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] f3 = 3'd0;
    logic [6:0] f7 = 7'd0;

    logic       regWR, memWR, aluS1, aluS2, doBranch, doJump;
    logic [1:0] wbCtrl;
    logic [3:0] aluOp;
    logic [2:0] branchCtrl, memCtrl;

    int checks = 0;
    int errors = 0;

    localparam logic [17:0] ZERO = 18'd0;

    controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .f7(f7),
        .regWR(regWR), .memWR(memWR), .wbCtrl(wbCtrl), .aluOp(aluOp),
        .aluS1(aluS1), .aluS2(aluS2), .branchCtrl(branchCtrl),
        .memCtrl(memCtrl), .doBranch(doBranch), .doJump(doJump)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] bundle();
        return {regWR, memWR, wbCtrl, aluOp, aluS1, aluS2,
                branchCtrl, memCtrl, doBranch, doJump};
    endfunction

    // Assemble an expected bundle from hand-written field values.
    function automatic logic [17:0] mk(input logic rw, input logic mw,
                                       input logic [1:0] wb, input logic [3:0] op,
                                       input logic s1, input logic s2,
                                       input logic [2:0] br, input logic [2:0] mc,
                                       input logic db, input logic dj);
        return {rw, mw, wb, op, s1, s2, br, mc, db, dj};
    endfunction

    task automatic check(input string tag, input logic [17:0] expected);
        logic [17:0] observed;
        observed = bundle();
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Present inputs just after an edge, then sample 1 time unit after the
    // next rising edge.
    task automatic step(input logic [6:0] op, input logic [2:0] fn3,
                        input logic [6:0] fn7);
        opcode = op;
        f3     = fn3;
        f7     = fn7;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Establish a known decoded value, then assert reset mid-cycle.
        step(7'b0110011, 3'b000, 7'b0000000);
        check("r_add_pre_reset", mk(1,0,2'b00,4'b0000,0,0,3'b000,3'b000,0,0));
        rst = 1'b1;
        #1;
        check("reset_async", ZERO);
        @(posedge clk);
        #1;
        check("reset_held", ZERO);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", ZERO);
        @(posedge clk);
        #1;
        check("reset_release_edge", mk(1,0,2'b00,4'b0000,0,0,3'b000,3'b000,0,0));

        // R-type sweep with funct7 = 0.
        for (int i = 0; i < 8; i++) begin
            step(7'b0110011, 3'(i), 7'b0000000);
            check($sformatf("r_f3_%0d", i),
                  mk(1,0,2'b00,{1'b0, 3'(i)},0,0,3'b000,3'b000,0,0));
        end
        step(7'b0110011, 3'b000, 7'b0100000);
        check("r_sub", mk(1,0,2'b00,4'b1000,0,0,3'b000,3'b000,0,0));
        step(7'b0110011, 3'b101, 7'b0100000);
        check("r_sra", mk(1,0,2'b00,4'b1101,0,0,3'b000,3'b000,0,0));
        step(7'b0110011, 3'b001, 7'b0100000);
        check("r_illegal_f7", ZERO);
        step(7'b0110011, 3'b000, 7'b0000001);
        check("r_illegal_m_ext", ZERO);

        // I-ALU.
        step(7'b0010011, 3'b101, 7'b0100000);
        check("i_srai", mk(1,0,2'b00,4'b1101,0,1,3'b000,3'b000,0,0));
        step(7'b0010011, 3'b001, 7'b0100000);
        check("i_slli_f7_ignored", mk(1,0,2'b00,4'b0001,0,1,3'b000,3'b000,0,0));
        step(7'b0010011, 3'b000, 7'b1111111);
        check("i_addi_neg_imm", mk(1,0,2'b00,4'b0000,0,1,3'b000,3'b000,0,0));

        // Loads and stores.
        step(7'b0000011, 3'b100, 7'b0000000);
        check("load_lbu", mk(1,0,2'b01,4'b0000,0,1,3'b000,3'b100,0,0));
        step(7'b0000011, 3'b011, 7'b0000000);
        check("load_illegal", ZERO);
        step(7'b0100011, 3'b010, 7'b0000000);
        check("store_sw", mk(0,1,2'b00,4'b0000,0,1,3'b000,3'b010,0,0));
        step(7'b0100011, 3'b100, 7'b0000000);
        check("store_illegal", ZERO);

        // Branches.
        step(7'b1100011, 3'b101, 7'b0000000);
        check("branch_bge", mk(0,0,2'b00,4'b0000,1,1,3'b101,3'b000,1,0));
        step(7'b1100011, 3'b010, 7'b0000000);
        check("branch_illegal", ZERO);

        // U/J types and an unknown opcode.
        step(7'b0110111, 3'b111, 7'b1010101);
        check("lui", mk(1,0,2'b00,4'b1001,0,1,3'b000,3'b000,0,0));
        step(7'b0010111, 3'b011, 7'b0000000);
        check("auipc", mk(1,0,2'b00,4'b0000,1,1,3'b000,3'b000,0,0));
        step(7'b1101111, 3'b110, 7'b0000000);
        check("jal", mk(1,0,2'b10,4'b0000,1,1,3'b000,3'b000,0,1));
        step(7'b1100111, 3'b000, 7'b0000000);
        check("jalr", mk(1,0,2'b10,4'b0000,0,1,3'b000,3'b000,0,1));
        step(7'b1100111, 3'b001, 7'b0000000);
        check("jalr_illegal", ZERO);
        step(7'b0011111, 3'b000, 7'b0000000);
        check("unknown_opcode", ZERO);

        // One-cycle latency: new inputs must not show before the edge.
        opcode = 7'b1101111;
        f3     = 3'b000;
        f7     = 7'b0000000;
        #2;
        check("latency_before_edge", ZERO);
        @(posedge clk);
        #1;
        check("latency_after_edge", mk(1,0,2'b10,4'b0000,1,1,3'b000,3'b000,0,1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- RV32I base-integer main decoder for the decode stage.
- Takes opcode, funct3 and funct7 of the current instruction and produces the register-file, memory, ALU, write-back and branch/jump control fields consumed downstream.
- Decode is combinational; all outputs are registered, forming the decode/execute control pipeline register.

Parameters:
- None.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  7  instruction[6:0]
- f3  input  3  instruction[14:12] (funct3)
- f7  input  7  instruction[31:25] (funct7)
- regWR  output  1  register-file write enable
- memWR  output  1  data-memory write enable
- wbCtrl  output  2  write-back select: 00 ALU result, 01 load data, 10 PC+4, 11 unused
- aluOp  output  4  ALU operation
- aluS1  output  1  ALU operand A select: 0 rs1, 1 PC
- aluS2  output  1  ALU operand B select: 0 rs2, 1 immediate
- branchCtrl  output  3  branch condition (funct3 of a valid branch, else 000)
- memCtrl  output  3  memory access size/sign (funct3 of a valid load/store, else 000)
- doBranch  output  1  instruction is a conditional branch
- doJump  output  1  instruction is JAL or JALR

Behaviour:
- Timing: all outputs update on the rising edge of clk, one cycle after inputs are presented. No handshake; a new decode every cycle.
- Reset: while rst=1, every output is 0 immediately, independent of clk. All-zero is the NOP/illegal bundle. Reset deassertion mid-stream resumes decode on the next edge.
- aluOp encoding is {bit, f3}:
  - ADD 0000, SUB 1000
  - SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101
  - OR 0110, AND 0111
  - PASSB 1001
- Unlisted output fields are 0 in every row below.
- R-type, opcode 0110011:
  - regWR=1, wbCtrl=00, aluS1=0, aluS2=0, aluOp={f7[5],f3}.
  - Legal only if f7=0000000, or f7=0100000 with f3∈{000,101}. Any other combination is illegal.
- I-ALU, opcode 0010011:
  - regWR=1, wbCtrl=00, aluS1=0, aluS2=1.
  - aluOp={f7[5],f3} when f3=101; otherwise {0,f3} (f7 ignored, including for f3=001).
- Load, opcode 0000011:
  - regWR=1, wbCtrl=01, aluS1=0, aluS2=1, aluOp=ADD, memCtrl=f3.
  - f3∈{011,110,111} is illegal.
- Store, opcode 0100011:
  - memWR=1, aluS1=0, aluS2=1, aluOp=ADD, memCtrl=f3, regWR=0.
  - f3>010 is illegal.
- Branch, opcode 1100011:
  - doBranch=1, branchCtrl=f3, aluS1=1, aluS2=1, aluOp=ADD (target), regWR=0.
  - f3∈{010,011} is illegal.
- LUI, opcode 0110111: regWR=1, wbCtrl=00, aluS2=1, aluOp=PASSB. f3 and f7 are ignored.
- AUIPC, opcode 0010111: regWR=1, wbCtrl=00, aluS1=1, aluS2=1, aluOp=ADD. f3 and f7 are ignored.
- JAL, opcode 1101111: regWR=1, wbCtrl=10, doJump=1, aluS1=1, aluS2=1, aluOp=ADD. f3 is ignored.
- JALR, opcode 1100111:
  - regWR=1, wbCtrl=10, doJump=1, aluS1=0, aluS2=1, aluOp=ADD.
  - f3≠000 is illegal.
- Any other opcode, or any illegal combination above: all outputs 0. regWR and memWR are never asserted for illegal encodings.
- doBranch and doJump are never simultaneously 1. memWR=1 implies regWR=0.

Test Plan:
- Reset: assert rst with opcode=0110011 applied → all outputs 0 asynchronously. Release rst → next edge gives regWR=1, aluOp=0000.
- R-type sweep: f3 000..111 with f7=0 gives aluOp 0000..0111. f7=0100000 with f3=000 gives 1000; with f3=101 gives 1101; with f3=001 gives all zeros.
- I-ALU: f3=101, f7=0100000 → aluOp=1101, aluS2=1. f3=001 with any f7 → 0001.
- Loads/stores: opcode 0000011, f3=100 → regWR=1, wbCtrl=01, memCtrl=100; f3=011 → zeros. Opcode 0100011, f3=010 → memWR=1, regWR=0, memCtrl=010; f3=100 → zeros.
- Branch: opcode 1100011, f3=101 → doBranch=1, branchCtrl=101, regWR=0; f3=010 → zeros.
- U/J types and default:
  - LUI → aluOp=1001, aluS2=1.
  - AUIPC → aluS1=1.
  - JAL → doJump=1, wbCtrl=10.
  - JALR f3=000 → doJump=1, aluS1=0.
  - Opcode 0011111 → all zeros.
  - Each result appears one cycle after the inputs are applied.
